// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO over a valid/ready handshake.
// Frames (start, data LSB first, optional parity, stop) are sent back-to-back while words are queued.
module uart_tx_fifo #(
  parameter int BAUD_DIV   = 5208,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          sys_clk_50M,
  input  logic                          rst_n,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);
  localparam logic        PAR_ODD  = (PARITY == 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t                 state, state_nxt;
  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [AW:0]            wr_ptr, rd_ptr;
  logic                   rdy_en, push, pop, empty, full;
  logic [15:0]            baud_cnt;
  logic                   baud_last;
  logic [2:0]             bit_idx;
  logic                   bit_last;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_bit;
  logic                   tx_nxt, done_nxt;

  // FIFO: extra pointer bit distinguishes full from empty
  assign fifo_level = wr_ptr - rd_ptr;
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (fifo_level == FULL_LVL);
  assign tx_ready   = rdy_en && !full;
  assign push       = tx_valid && tx_ready;

  assign baud_last = (baud_cnt == 16'(BAUD_DIV - 1));
  assign bit_last  = (state == S_DATA) ? (bit_idx == 3'(DATA_BITS - 1))
                                       : (bit_idx == 3'(STOP_BITS - 1));

  always_ff @(posedge sys_clk_50M) begin
    if (push) mem[wr_ptr[AW-1:0]] <= tx_data;
  end

  always_ff @(posedge sys_clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge sys_clk_50M or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!empty) state_nxt = S_START;
      S_START: if (baud_last) state_nxt = S_DATA;
      S_DATA:  if (baud_last && bit_last) state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
      S_PAR:   if (baud_last) state_nxt = S_STOP;
      S_STOP:  if (baud_last && bit_last) state_nxt = empty ? S_IDLE : S_START;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Line value for the next cycle; tx lags the FSM by one register stage
  always_comb begin
    pop      = 1'b0;
    done_nxt = 1'b0;
    tx_nxt   = 1'b1;
    case (state)
      S_IDLE:  pop = !empty;
      S_START: tx_nxt = 1'b0;
      S_DATA:  tx_nxt = shreg[0];
      S_PAR:   tx_nxt = par_bit;
      S_STOP: begin
        done_nxt = baud_last && bit_last;
        pop      = done_nxt && !empty;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      tx      <= tx_nxt;
      tx_done <= done_nxt;
      busy    <= (state != S_IDLE) || !empty;
      if (pop) begin
        shreg    <= mem[rd_ptr[AW-1:0]];
        par_bit  <= (^mem[rd_ptr[AW-1:0]]) ^ PAR_ODD;
        baud_cnt <= '0;
        bit_idx  <= '0;
      end else if (state == S_IDLE) begin
        baud_cnt <= '0;
        bit_idx  <= '0;
      end else if (baud_last) begin
        baud_cnt <= '0;
        if (state == S_DATA) begin
          shreg   <= shreg >> 1;
          bit_idx <= bit_last ? 3'd0 : bit_idx + 3'd1;
        end else if (state == S_STOP) begin
          bit_idx <= bit_last ? 3'd0 : bit_idx + 3'd1;
        end else begin
          bit_idx <= '0;
        end
      end else begin
        baud_cnt <= baud_cnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo: three frame configurations, each checked every cycle
// against a queue-based model of accepted words, pop times and frame bit sequences.
module tb_uart_tx_fifo;
  localparam int NC = 3;
  localparam int BD_T  [NC] = '{16, 16, 5};
  localparam int DB_T  [NC] = '{8, 7, 5};
  localparam int PAR_T [NC] = '{0, 1, 2};
  localparam int SB_T  [NC] = '{1, 2, 1};
  localparam int DEP_T [NC] = '{4, 4, 2};

  typedef struct { int w; int a; } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0, mode = 0, burst_pct = 0;
  int   nchk = 0, nbad = 0;

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bit b of a frame: 0 = start, 1..db = data LSB first, then parity (if any), then stop.
  function automatic logic frame_bit(input int w, input int b, input int db, input int par);
    int ones;
    if (b == 0) return 1'b0;
    if (b <= db) return 1'((w >> (b - 1)) & 1);
    if (par != 0 && b == db + 1) begin
      ones = 0;
      for (int i = 0; i < db; i++) ones += (w >> i) & 1;
      return (par == 1) ? 1'(ones % 2) : 1'(1 - ones % 2);
    end
    return 1'b1;
  endfunction

  for (genvar g = 0; g < NC; g++) begin : cfg
    localparam int BD  = BD_T[g];
    localparam int DB  = DB_T[g];
    localparam int PAR = PAR_T[g];
    localparam int SB  = SB_T[g];
    localparam int DEP = DEP_T[g];
    localparam int FL  = (1 + DB + ((PAR != 0) ? 1 : 0) + SB) * BD;
    localparam int LW  = $clog2(DEP) + 1;

    logic          tx_valid, tx_ready, tx, busy, tx_done;
    logic [DB-1:0] tx_data;
    logic [LW-1:0] fifo_level;
    int            pending;

    uart_tx_fifo #(
      .BAUD_DIV(BD), .DATA_BITS(DB), .PARITY(PAR), .STOP_BITS(SB), .FIFO_DEPTH(DEP)
    ) dut (
      .sys_clk_50M(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .tx_data(tx_data), .tx(tx), .busy(busy), .tx_done(tx_done), .fifo_level(fifo_level)
    );

    // Producer: random data every cycle; valid pattern chosen by the global mode
    initial begin : drv
      int seq;
      bit acc, sent;
      tx_valid = 1'b0;
      tx_data  = '0;
      seq = 0;
      sent = 1'b0;
      forever begin
        @(negedge clk);
        acc = tx_valid && tx_ready;
        @(posedge clk);
        #1;
        if (acc) seq++;
        if (mode != 2) seq = 0;
        if (mode != 3) sent = 1'b0;
        else if (acc)  sent = 1'b1;
        tx_data = DB'($urandom);
        case (mode)
          1: tx_valid = ($urandom_range(0, 99) < burst_pct);
          2: begin tx_valid = 1'b1; tx_data = DB'(8'h10 + seq); end
          3: begin tx_valid = !sent; tx_data = DB'(8'h3C); end
          default: tx_valid = 1'b0;
        endcase
      end
    end

    // Reference: a word accepted at edge A is popped at max(A+1, previous done edge),
    // its frame starts on the line one edge later and lasts FL cycles.
    initial begin : mdl
      int   lvl, done_e, cur_e, cur_w, rel, lvl_prev, k;
      bit   in_fr;
      logic etx;
      ent_t q[$];
      cur_e = -100000; cur_w = 0; rel = 0; lvl_prev = 0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          q.delete();
          cur_e = -100000;
          lvl_prev = 0;
          rel = cyc + 1;
          chk($sformatf("c%0d.rst_tx", g), tx, 1);
          chk($sformatf("c%0d.rst_busy", g), busy, 0);
          chk($sformatf("c%0d.rst_done", g), tx_done, 0);
          chk($sformatf("c%0d.rst_ready", g), tx_ready, 0);
          chk($sformatf("c%0d.rst_level", g), fifo_level, 0);
        end else begin
          done_e = cur_e + FL - 1;
          if (q.size() > 0 && cyc == imax(q[0].a + 1, done_e) + 1) begin
            cur_w = q[0].w;
            cur_e = cyc;
            void'(q.pop_front());
            done_e = cur_e + FL - 1;
          end
          lvl = q.size();
          if (q.size() > 0 && imax(q[0].a + 1, done_e) <= cyc) lvl--;
          k = cyc - cur_e;
          in_fr = (k >= 0 && k < FL);
          etx = in_fr ? frame_bit(cur_w, k / BD, DB, PAR) : 1'b1;
          chk($sformatf("c%0d.tx", g), tx, etx);
          chk($sformatf("c%0d.tx_done", g), tx_done, (cyc == done_e));
          chk($sformatf("c%0d.busy", g), busy, (in_fr || lvl_prev > 0));
          chk($sformatf("c%0d.tx_ready", g), tx_ready, (cyc >= rel && lvl < DEP));
          chk($sformatf("c%0d.level", g), fifo_level, lvl);
          lvl_prev = lvl;
          if (tx_valid && tx_ready) q.push_back('{w: int'(tx_data), a: cyc + 1});
        end
        pending = q.size();
      end
    end
  end

  task automatic wait_drain();
    int n;
    n = 0;
    repeat (3) @(posedge clk);
    while ((cfg[0].busy || cfg[1].busy || cfg[2].busy) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_busy", {cfg[0].busy, cfg[1].busy, cfg[2].busy}, 0);
    repeat (4) @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset: line high, nothing transmitted
    repeat (1000) @(posedge clk);

    // Random bursts: mixes idle gaps, back-to-back frames and full FIFOs
    mode = 1;
    for (int r = 0; r < 12; r++) begin
      burst_pct = $urandom_range(1, 60);
      repeat (300) @(posedge clk);
    end
    mode = 0;
    wait_drain();

    // Hold valid with incrementing data until the FIFO is full
    @(posedge clk);
    mode = 2;
    repeat (30) @(negedge clk);
    chk("fill_level", cfg[0].fifo_level, 4);
    chk("fill_ready", cfg[0].tx_ready, 0);
    repeat (370) @(posedge clk);
    mode = 0;
    wait_drain();

    // Three words, then reset while the first frame is in data bit 3
    @(posedge clk);
    mode = 2;
    repeat (3) @(posedge clk);
    mode = 0;
    repeat (70) @(posedge clk);
    #3;
    chk("pre_rst_tx", cfg[0].tx, 0);
    chk("pre_rst_level", cfg[0].fifo_level, 2);
    rst_n = 1'b0;
    #1;
    chk("async_tx", cfg[0].tx, 1);
    chk("async_level", cfg[0].fifo_level, 0);
    chk("async_busy", cfg[0].busy, 0);
    chk("async_done", cfg[0].tx_done, 0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // Single 0x3C after reset
    @(posedge clk);
    mode = 3;
    repeat (20) @(posedge clk);
    mode = 0;
    wait_drain();

    for (int g = 0; g < NC; g++) begin
      case (g)
        0: chk("c0.leftover", cfg[0].pending, 0);
        1: chk("c1.leftover", cfg[1].pending, 0);
        default: chk("c2.leftover", cfg[2].pending, 0);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nbad);
    $finish;
  end
endmodule
